// File: rtl/static_screen_pkg.sv
// Shared definitions for the static-screen path: FSM encoding and default widths.
package static_screen_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_X_W    = 8;
    localparam int DEF_Y_W    = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/wrap_cnt.sv
// Wrapping counter 0..limit-1 with synchronous clear; at_limit flags the last count.
module wrap_cnt #(
    parameter int W = 8
) (
    input  logic         sck,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         at_limit
);

    assign at_limit = (count == (limit - W'(1)));

    always_ff @(posedge sck) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= at_limit ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/raster_addr_acc.sv
// 2D raster window walker: produces linear address, x/y and eol/eof strobes per adv.
module raster_addr_acc
    import static_screen_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int X_W    = DEF_X_W,
    parameter int Y_W    = DEF_Y_W
) (
    input  logic              sck,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [X_W-1:0]    hsize,
    input  logic [Y_W-1:0]    vsize,
    input  logic              adv,
    output logic [ADDR_W-1:0] addr,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic              busy,
    output logic              eol,
    output logic              eof,
    output logic              err
);

    // Handshake: start and adv are single-cycle qualifiers sampled on each rising
    // edge; adv is consumed only while busy, and a valid start wins over adv.
    state_e            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] line_base;
    logic [X_W-1:0]    hsize_q;
    logic [Y_W-1:0]    vsize_q;
    logic              cont_q;

    logic start_ok, start_bad, adv_acc;
    logic x_at, y_at, frame_end, hold_end;

    assign start_ok  = start && (hsize != '0) && (vsize != '0);
    assign start_bad = start && !start_ok;
    assign adv_acc   = adv && (state == ST_RUN) && !start_ok;
    assign frame_end = x_at && y_at;
    // A one-shot frame keeps its last coordinates on the final pixel.
    assign hold_end  = frame_end && !cont_q;
    assign busy      = (state == ST_RUN);

    wrap_cnt #(.W(X_W)) u_x_cnt (
        .sck      (sck),
        .rst      (rst),
        .clr      (start_ok),
        .inc      (adv_acc && !hold_end),
        .limit    (hsize_q),
        .count    (x),
        .at_limit (x_at)
    );

    wrap_cnt #(.W(Y_W)) u_y_cnt (
        .sck      (sck),
        .rst      (rst),
        .clr      (start_ok),
        .inc      (adv_acc && x_at && !hold_end),
        .limit    (vsize_q),
        .count    (y),
        .at_limit (y_at)
    );

    always_ff @(posedge sck) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            line_base <= '0;
            base_q    <= '0;
            stride_q  <= '0;
            hsize_q   <= '0;
            vsize_q   <= '0;
            cont_q    <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            err       <= 1'b0;
        end else begin
            eol <= 1'b0;
            eof <= 1'b0;
            err <= start_bad;
            if (start_ok) begin
                base_q    <= base_addr;
                stride_q  <= stride;
                hsize_q   <= hsize;
                vsize_q   <= vsize;
                cont_q    <= cont;
                addr      <= base_addr;
                line_base <= base_addr;
                state     <= ST_RUN;
            end else if (adv_acc) begin
                if (!x_at) begin
                    addr <= addr + ADDR_W'(1);
                end else if (!y_at) begin
                    line_base <= line_base + stride_q;
                    addr      <= line_base + stride_q;
                    eol       <= 1'b1;
                end else begin
                    eol <= 1'b1;
                    eof <= 1'b1;
                    if (cont_q) begin
                        addr      <= base_q;
                        line_base <= base_q;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: doc/raster_addr_acc.md
# raster_addr_acc

Parametrised 2D raster address accumulator for the static-screen path. It generalises the loadable pixel counter into a window walker. A programmable base address, line length, line count and line stride produce a linear memory address, x/y coordinates, and end-of-line and end-of-frame strobes. It sits between the display timing logic, which drives `adv` once per pixel, and the frame memory read port, which consumes `addr`.

## Interface
- `ADDR_W`, 13, width of the linear memory address.
- `X_W`, 8, width of the x coordinate and of `hsize`.
- `Y_W`, 8, width of the y coordinate and of `vsize`.
- `sck`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  latches the config inputs and begins a frame.
- `cont`  in  1  continuous mode, sampled with `start`; the frame wraps instead of stopping.
- `base_addr`  in  ADDR_W  address of pixel (0,0).
- `stride`  in  ADDR_W  address increment between line starts.
- `hsize`  in  X_W  pixels per line; must be ≥1.
- `vsize`  in  Y_W  lines per frame; must be ≥1.
- `adv`  in  1  advance one pixel; ignored when not busy.
- `addr`  out  ADDR_W  current pixel address.
- `x`  out  X_W  current column.
- `y`  out  Y_W  current line.
- `busy`  out  1  high in RUN.
- `eol`  out  1  one-cycle pulse: the last pixel of a line was consumed.
- `eof`  out  1  one-cycle pulse: the last pixel of the frame was consumed.
- `err`  out  1  one-cycle pulse: `start` was issued with `hsize`==0 or `vsize`==0.

## Operation
- States: IDLE and RUN.
- Reset values: state IDLE, `addr`=0, `x`=0, `y`=0, `busy`=0, `eol`=0, `eof`=0, `err`=0, all latched config registers = 0.
- `rst` has priority over every other input.
- `start` with `hsize`≠0 and `vsize`≠0, in any state:
  - latch `base_addr`, `stride`, `hsize`, `vsize` and `cont`;
  - set `addr`=`base_addr`, `line_base`=`base_addr`, `x`=0, `y`=0;
  - go to RUN.
  - A `start` during RUN restarts the frame; an `adv` in the same cycle is discarded.
- `start` with `hsize`==0 or `vsize`==0: pulse `err`, take no other action, leave the state unchanged.
- In RUN, each `adv` acts on the latched `hsize`/`vsize`:
  - Not end of line: `x`+=1, `addr`+=1.
  - End of line (`x`==`hsize`-1) but not the last line: `x`=0, `y`+=1, `line_base`+=`stride`, `addr`=new `line_base`, pulse `eol`.
  - End of frame (`x`==`hsize`-1 and `y`==`vsize`-1): pulse `eol` and `eof`.
    - With `cont`=0: go to IDLE; `addr`, `x`, `y` hold their last values.
    - With `cont`=1: reload `addr`/`line_base`=latched base, `x`=0, `y`=0, stay in RUN.
- `adv` in IDLE has no effect.
- Arithmetic: all address sums are modulo 2^ADDR_W and wrap silently. `stride` is independent of `hsize`, so a stride larger than `hsize` walks a sub-window. `stride`=0 rescans the same line.
- `hsize`=1 gives `eol` on every `adv`. `hsize`=`vsize`=1 gives `eol`+`eof` on the first `adv`.

## Timing
- All outputs are registered.
- The `adv` sampled at edge N makes the new `addr`/`x`/`y` visible after edge N. `eol`/`eof` are high in that same cycle, for exactly one cycle.
- `start` at edge N gives `busy`=1 and `addr`=`base_addr` after edge N; the first `adv` is accepted at edge N+1.
- One pixel per clock is sustainable: `adv` held high advances every cycle, with no bubble at line or frame boundaries.
- `rst` asserted mid-frame: after that edge all outputs are at reset values; strobes do not fire.
- Config inputs are don't-care except in the `start` cycle.

## Structure
- Shared package `static_screen_pkg`:
  - state encoding (IDLE=1'b0, RUN=1'b1);
  - default widths ADDR_W/X_W/Y_W.
- Sub-module `wrap_cnt`: parametrised width; inputs `clr`, `inc`, `limit`; outputs `count` and a combinational `at_limit` (`count`==`limit`-1). Instantiated once for x and once for y.
- The top level holds the FSM, the `line_base` and `addr` accumulators, the config latches and the strobe registers.

## Test plan
- **Linear scan:** `base_addr`=0x100, `hsize`=4, `vsize`=2, `stride`=4, `cont`=0, `start`, then 8×`adv` → `addr` 0x100..0x107. `eol` after the 4th and 8th `adv`; `eof` after the 8th; `busy`=0 after the 8th.
- **Sub-window:** `base_addr`=0x10, `hsize`=3, `vsize`=3, `stride`=0x20, `adv` held high → `addr` 0x10,11,12,30,31,32,50,51,52 with no stall cycles.
- **Continuous wrap:** `cont`=1, `hsize`=2, `vsize`=1, `base_addr`=5 → `addr` 5,6,5,6…. `eof` on every second `adv`; `busy` stays 1.
- **Address overflow:** ADDR_W=13, `base_addr`=0x1FFE, `hsize`=4, `vsize`=1 → `addr` 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- **Error and restart:** `start` with `vsize`=0 → `err` pulse, `busy` unchanged. `start` mid-frame with `base_addr`=0x40 and `adv`=1 in the same cycle → `addr`=0x40, `x`=`y`=0.
- **Reset mid-frame:** `rst` at `x`=2, `y`=1 → next cycle all outputs 0, `busy`=0, no `eol`/`eof`.
